// File: rtl/prog_mem_pkg.sv
// Shared types and default sizing for the program-memory controller.
package prog_mem_pkg;

    localparam int IW_DEF = 12;
    localparam int AW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Instruction storage: one synchronous write port, one registered read port, no reset.
module prog_mem_array #(
    parameter int IW = 12,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: burst loader with running XOR checksum and a
// single-cycle fetch port that is only served while the loader is idle.
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic [AW-1:0] fetch_addr,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_count,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_abort,
    output logic          ld_done,
    output logic          busy,
    output logic [IW-1:0] checksum
);

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic          accept;
    logic          fetch_p0;
    logic          vld_p1;
    logic [IW-1:0] rdata_p1;

    assign ld_ready = (state == LOAD) && !ld_abort;
    assign accept   = ld_valid && ld_ready;
    assign fetch_p0 = fetch_en && (state == IDLE);
    assign ld_done  = (state == DONE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_nxt = (ld_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (ld_abort) begin
                    state_nxt = IDLE;
                end else if (ld_valid && remaining == (AW+1)'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Abort leaves ptr/remaining/checksum as they were; the next ld_start reloads them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
            checksum  <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= fetch_p0;
            if (state == IDLE && ld_start) begin
                ptr       <= ld_base;
                remaining <= ld_count;
                checksum  <= '0;
            end else if (accept) begin
                ptr       <= ptr + AW'(1);
                remaining <= remaining - (AW+1)'(1);
                checksum  <= checksum ^ ld_data;
            end
        end
    end

    prog_mem_array #(
        .IW(IW),
        .AW(AW)
    ) u_array (
        .clk  (clk),
        .we   (accept),
        .waddr(ptr),
        .wdata(ld_data),
        .re   (fetch_p0),
        .raddr(fetch_addr),
        .rdata(rdata_p1)
    );

    // ---- stage p1: fetched word, forced to zero when no fetch was served
    assign instr       = vld_p1 ? rdata_p1 : '0;
    assign instr_valid = vld_p1;

endmodule

// File: doc/prog_mem_ctrl.md
PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

Interface
REQ-001 The block SHALL have parameter IW, default 12, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter AW, default 8, meaning address width, with DEPTH = 2**AW words.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports clk and rst.
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- fetch_en  input  1  fetch request enable.
- fetch_addr  input  AW  fetch address.
- instr  output  IW  fetched instruction, registered.
- instr_valid  output  1  instr holds valid data this cycle.
- ld_start  input  1  begin a load burst; sampled only in IDLE.
- ld_base  input  AW  first load address, latched on ld_start.
- ld_count  input  AW+1  number of words in the burst (0..DEPTH), latched on ld_start.
- ld_valid  input  1  ld_data is valid.
- ld_ready  output  1  block accepts ld_data this cycle.
- ld_data  input  IW  instruction word to load.
- ld_abort  input  1  terminate the current burst.
- ld_done  output  1  one-cycle pulse when a burst completes normally.
- busy  output  1  high in LOAD and DONE.
- checksum  output  IW  running XOR of the words accepted in the current or last burst.

Function
REQ-005 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-006 In IDLE with ld_start=1, the FSM SHALL clear checksum, latch ld_base into ptr and ld_count into remaining, then enter LOAD, or enter DONE if ld_count=0.
REQ-007 ld_ready SHALL equal (state==LOAD && !ld_abort), combinationally.
REQ-008 On each accepted word (ld_valid && ld_ready), the block SHALL perform all of the following in the same clock edge:
- write mem[ptr] <= ld_data;
- increment ptr modulo DEPTH, so that address DEPTH-1 wraps to 0;
- decrement remaining;
- update checksum <= checksum ^ ld_data.
REQ-009 When the accepted word has remaining==1, the FSM SHALL enter DONE.
REQ-010 The FSM SHALL hold DONE for exactly one cycle, assert ld_done during that cycle, and then return to IDLE.
REQ-011 ld_abort in LOAD SHALL take priority over ld_valid: no write occurs, the FSM enters IDLE next cycle, ld_done stays 0, and checksum holds its partial value.
REQ-012 ld_start outside IDLE SHALL be ignored, and ld_abort outside LOAD SHALL be ignored.
REQ-013 Fetch SHALL have 1-cycle latency: if fetch_en=1 and state==IDLE at edge N, then at N+1 instr=mem[fetch_addr] and instr_valid=1.
REQ-014 Otherwise (fetch_en=0, or state is LOAD or DONE), the block SHALL register instr=0 and instr_valid=0.
REQ-015 Fetch and load SHALL never access the array in the same cycle, so no read-during-write case exists.
REQ-016 Memory contents SHALL be undefined until written and SHALL persist until overwritten.

Reset
REQ-017 While rst=1, the block SHALL hold: state=IDLE, instr=0, instr_valid=0, ld_done=0, busy=0, ld_ready=0, checksum=0, ptr=0 and remaining=0.
REQ-018 Reset SHALL NOT clear the memory array; reset during LOAD abandons the burst and keeps words already written.

Structure
REQ-019 A shared package prog_mem_pkg SHALL hold the state enum typedef (IDLE, LOAD, DONE) and the default IW/AW constants.
REQ-020 The storage SHALL be a sub-module prog_mem_array (DEPTH x IW, one synchronous write port, one registered read port, no reset).
REQ-021 The FSM, pointer, counter and checksum logic SHALL reside in prog_mem_ctrl.

Verification (IW=12, AW=8)
REQ-022 The bench SHALL cover: ld_start base=0x10 count=3, data 0x123, 0x456, 0x789 back-to-back -> ld_done pulses the cycle after the third accept; checksum=0x2FC; then fetch 0x11 -> instr=0x456 with instr_valid=1 one cycle later.
REQ-023 The bench SHALL cover: base=0xFE count=3, data 0xA01, 0xA02, 0xA03 -> fetches of 0xFE, 0xFF and 0x00 return 0xA01, 0xA02 and 0xA03.
REQ-024 The bench SHALL cover: ld_valid gapped (1,0,0,1) with count=2 -> exactly two writes; busy stays 1 throughout the gaps; ld_done pulses once.
REQ-025 The bench SHALL cover: count=4, ld_abort after the first accept -> only the first word is written; ld_done never asserts; state returns to IDLE; ld_start is accepted again next cycle.
REQ-026 The bench SHALL cover: fetch_en=1 during LOAD -> instr=0 and instr_valid=0; ld_start during LOAD -> ignored; count=0 -> DONE for one cycle with checksum=0.
REQ-027 The bench SHALL cover: rst asserted mid-burst after two accepts -> all outputs 0 asynchronously; after release, both written words are readable and unwritten addresses are unchanged.
